// File: rtl/dtree_leaf_bcast.sv
// Broadcast transmitter: serves each leaf of an instance tree in descending order,
// checks the returned echo, then counts settle cycles up to LAST and reports done.
module dtree_leaf_bcast #(
    parameter int unsigned NLEAF   = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned LAST    = 13
) (
    input  logic                     clk,
    input  logic                     reset_l,
    input  logic                     start,
    input  logic [WIDTH-1:0]         base,
    output logic [$clog2(NLEAF)-1:0] leaf_sel,
    output logic [WIDTH-1:0]         leaf_data,
    output logic                     leaf_valid,
    input  logic                     leaf_ack,
    input  logic [WIDTH-1:0]         leaf_echo,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [31:0]              cyc
);

    localparam int unsigned     SW       = $clog2(NLEAF);
    localparam int unsigned     TW       = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0]   IDX_TOP  = SW'(NLEAF - 1);
    localparam logic [TW-1:0]   TMO_MAX  = TW'(TIMEOUT - 1);
    localparam logic [31:0]     CYC_LAST = 32'(LAST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [SW-1:0]     idx_q;
    logic [SW-1:0]     idx_d;
    logic [TW-1:0]     tmo_q;
    logic [TW-1:0]     tmo_d;
    logic [WIDTH-1:0]  base_q;
    logic [WIDTH-1:0]  base_d;
    logic              err_d;
    logic [31:0]       cyc_d;
    logic              advance;

    // Next-state and datapath decisions; outputs are registered from these values.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        base_d  = base_q;
        err_d   = err;
        cyc_d   = cyc;
        advance = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    base_d  = base;
                    idx_d   = IDX_TOP;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // A stalled leaf is skipped after TIMEOUT cycles and flagged as an error.
                if (leaf_ack) begin
                    advance = 1'b1;
                    if (leaf_echo != leaf_data) begin
                        err_d = 1'b1;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    advance = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end

                if (advance) begin
                    tmo_d = '0;
                    if (idx_q == '0) begin
                        state_d = S_HOLD;
                        cyc_d   = '0;
                    end else begin
                        idx_d = idx_q - SW'(1);
                    end
                end
            end
            S_HOLD: begin
                cyc_d = cyc + 32'd1;
                if (cyc_d == CYC_LAST) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tmo_q      <= '0;
            base_q     <= '0;
            err        <= 1'b0;
            cyc        <= '0;
            leaf_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            leaf_sel   <= '0;
            leaf_data  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            base_q     <= base_d;
            err        <= err_d;
            cyc        <= cyc_d;
            leaf_valid <= (state_d == S_SEND);
            busy       <= (state_d == S_SEND) || (state_d == S_HOLD);
            done       <= (state_d == S_DONE);
            leaf_sel   <= idx_d;
            leaf_data  <= base_d + WIDTH'(idx_d);
        end
    end

endmodule

// File: tb/tb_dtree_leaf_bcast.sv
// Directed bench for dtree_leaf_bcast: a trace model built per run from the leaf
// behaviour, compared every cycle, plus literal sequence and latency expectations.
module tb_dtree_leaf_bcast;

    localparam int NLEAF   = 4;
    localparam int TIMEOUT = 8;
    localparam int LAST    = 13;

    logic        clk;
    logic        reset_l;
    logic        start;
    logic [31:0] base;
    logic [1:0]  leaf_sel;
    logic [31:0] leaf_data;
    logic        leaf_valid;
    logic        leaf_ack;
    logic [31:0] leaf_echo;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] cyc;

    dtree_leaf_bcast #(
        .NLEAF  (NLEAF),
        .WIDTH  (32),
        .TIMEOUT(TIMEOUT),
        .LAST   (LAST)
    ) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .start     (start),
        .base      (base),
        .leaf_sel  (leaf_sel),
        .leaf_data (leaf_data),
        .leaf_valid(leaf_valid),
        .leaf_ack  (leaf_ack),
        .leaf_echo (leaf_echo),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cyc       (cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaf responder: dly[l] = cycles before ack (-1 = never), bad[l] = wrong echo.
    int          dly [NLEAF];
    bit          bad [NLEAF];
    bit          stray_ack;
    logic [31:0] run_base;
    int          wait_n;
    int          eff;
    logic        last_v;
    logic [1:0]  last_s;

    always_comb begin
        eff       = (last_v && last_s == leaf_sel) ? wait_n : 0;
        leaf_ack  = stray_ack;
        leaf_echo = 32'hDEAD_BEEF;
        if (leaf_valid) begin
            if (dly[leaf_sel] >= 0 && eff == dly[leaf_sel]) leaf_ack = 1'b1;
            leaf_echo = bad[leaf_sel] ? 32'd7 : run_base + 32'(leaf_sel);
        end
    end

    always @(posedge clk) begin
        last_v <= leaf_valid;
        last_s <= leaf_sel;
        wait_n <= (leaf_valid && !leaf_ack) ? eff + 1 : 0;
    end

    typedef struct {
        bit          valid;
        int          sel;
        logic [31:0] data;
        bit          busy;
        bit          done;
        bit          err;
        logic [31:0] cyc;
        bit          chk_sd;
        bit          chk_cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        exp_cur;
    logic [31:0] obs_data[$];
    int          obs_sel[$];
    bit          prev_v;
    int          prev_s;
    int          cycle_no;
    int          t0;
    int          n_vec;
    int          n_err;

    function automatic exp_t mk(bit v, int s, logic [31:0] d, bit b, bit dn, bit e,
                                logic [31:0] c, bit csd, bit cc);
        exp_t r;
        r.valid = v; r.sel = s; r.data = d; r.busy = b; r.done = dn; r.err = e;
        r.cyc = c; r.chk_sd = csd; r.chk_cyc = cc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cycle_no, act, expv);
        end
    endtask

    task automatic check_cycle();
        chk("valid", 32'(leaf_valid), 32'(exp_cur.valid));
        chk("busy",  32'(busy),       32'(exp_cur.busy));
        chk("done",  32'(done),       32'(exp_cur.done));
        chk("err",   32'(err),        32'(exp_cur.err));
        if (exp_cur.chk_sd) begin
            chk("sel",  32'(leaf_sel), 32'(exp_cur.sel));
            chk("data", leaf_data,     exp_cur.data);
        end
        if (exp_cur.chk_cyc) chk("cyc", cyc, exp_cur.cyc);
    endtask

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (q.size() > 0) exp_cur = q.pop_front();
        @(negedge clk);
        cycle_no++;
        check_cycle();
        if (leaf_valid && (!prev_v || 32'(leaf_sel) != 32'(prev_s))) begin
            obs_sel.push_back(int'(leaf_sel));
            obs_data.push_back(leaf_data);
        end
        prev_v = leaf_valid;
        prev_s = int'(leaf_sel);
    endtask

    task automatic set_leaves();
        for (int i = 0; i < NLEAF; i++) begin
            dly[i] = 0;
            bad[i] = 1'b0;
        end
    endtask

    // Pulse start for one edge; if the model is idle/done, predict the whole run.
    task automatic start_run(input logic [31:0] b);
        int n;
        bit fail;
        bit e;
        start = 1'b1;
        base  = b;
        if (!exp_cur.busy) begin
            run_base = b;
            t0 = cycle_no;
            q.delete();
            obs_data.delete();
            obs_sel.delete();
            e = 1'b0;
            for (int l = NLEAF - 1; l >= 0; l--) begin
                fail = bad[l];
                n    = dly[l] + 1;
                if (dly[l] < 0 || dly[l] >= TIMEOUT) begin
                    n    = TIMEOUT;
                    fail = 1'b1;
                end
                for (int j = 0; j < n; j++) q.push_back(mk(1, l, b + 32'(l), 1, 0, e, 0, 1, 0));
                if (fail) e = 1'b1;
            end
            for (int c = 0; c < LAST; c++) q.push_back(mk(0, 0, 0, 1, 0, e, 32'(c), 0, 1));
            q.push_back(mk(0, 0, 0, 0, 1, e, 32'(LAST), 0, 1));
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat, input bit exp_err);
        int guard;
        guard = 0;
        while (!done && guard < 100) begin
            tick();
            guard++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("done_lat",  32'(cycle_no - t0), 32'(exp_lat));
        chk("cyc_done",  cyc, 32'd13);
        chk("err_done",  32'(err), 32'(exp_err));
    endtask

    task automatic chk_seq(input logic [31:0] d3, input logic [31:0] d2,
                           input logic [31:0] d1, input logic [31:0] d0);
        logic [31:0] d[4];
        d[0] = d3; d[1] = d2; d[2] = d1; d[3] = d0;
        chk("seq_len", 32'(obs_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
            chk("seq_sel",  32'(obs_sel[i]), 32'(3 - i));
            chk("seq_data", obs_data[i], d[i]);
        end
    endtask

    task automatic drop_reset();
        reset_l = 1'b0;
        #1;
        chk("rst_valid", 32'(leaf_valid), 32'd0);
        chk("rst_sel",   32'(leaf_sel),   32'd0);
        chk("rst_data",  leaf_data,       32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_err",   32'(err),        32'd0);
        chk("rst_cyc",   cyc,             32'd0);
        exp_cur = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
        q.delete();
        prev_v = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cycle_no = 0; t0 = 0;
        prev_v = 1'b0; prev_s = 0;
        start = 1'b0; base = '0; stray_ack = 1'b0; run_base = '0;
        set_leaves();
        exp_cur = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
        reset_l = 1'b0;
        repeat (2) tick();
        reset_l = 1'b1;
        repeat (2) tick();

        // Immediate ack, base 0.
        start_run(32'd0);
        wait_done(18, 1'b0);
        chk_seq(32'd3, 32'd2, 32'd1, 32'd0);
        repeat (2) tick();

        // Wrapping offsets.
        start_run(32'hFFFF_FFFE);
        wait_done(18, 1'b0);
        chk_seq(32'd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Leaf 2 returns a wrong echo.
        bad[2] = 1'b1;
        start_run(32'd0);
        wait_done(18, 1'b1);
        set_leaves();

        // Leaf 3 acks after 3 extra cycles: no error, done 3 cycles later.
        dly[3] = 3;
        start_run(32'd0);
        wait_done(21, 1'b0);
        set_leaves();

        // Leaf 1 never acks: skipped after TIMEOUT cycles.
        dly[1] = -1;
        start_run(32'd0);
        wait_done(25, 1'b1);
        chk_seq(32'd3, 32'd2, 32'd1, 32'd0);
        set_leaves();

        // Restart from DONE clears err.
        start_run(32'd10);
        chk("err_cleared", 32'(err), 32'd0);
        wait_done(18, 1'b0);
        chk_seq(32'd13, 32'd12, 32'd11, 32'd10);

        // Starts during SEND and HOLD, and a stray ack in HOLD, are ignored.
        start_run(32'd5);
        start_run(32'd99);
        repeat (5) tick();
        start_run(32'd77);
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        wait_done(18, 1'b0);
        chk_seq(32'd8, 32'd7, 32'd6, 32'd5);

        // Reset mid-SEND at idx 2, then a full run from leaf 3.
        start_run(32'h100);
        tick();
        chk("mid_sel", 32'(leaf_sel), 32'd2);
        drop_reset();
        repeat (2) tick();
        reset_l = 1'b1;
        tick();
        start_run(32'd0);
        wait_done(18, 1'b0);
        chk_seq(32'd3, 32'd2, 32'd1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dtree_leaf_bcast.md
# dtree_leaf_bcast

Broadcast transmitter that delivers a per-leaf 32-bit value to each leaf of an instance tree over a shared select/valid/ack channel. It checks the echo returned by each leaf, then runs a settle/finish cycle counter. It is the driving end for leaf modules that capture a value on `posedge clk` and later self-check against it. It sits at the top of the test hierarchy and owns the run-to-finish sequencing.

## Interface
Parameters:
- NLEAF, 4, number of leaves; must be 2 or more. Select width is SW = $clog2(NLEAF).
- WIDTH, 32, width of the data and echo fields.
- TIMEOUT, 8, maximum number of cycles a single leaf transfer may wait for ack.
- LAST, 13, value of `cyc` at which `done` asserts.

Ports:
- clk, in, 1: single clock; all state changes on its rising edge.
- reset_l, in, 1: asynchronous, active-low reset.
- start, in, 1: begins a broadcast run. Sampled only in IDLE or DONE.
- base, in, WIDTH: value offset. Latched at start.
- leaf_sel, out, SW: index of the leaf being addressed.
- leaf_data, out, WIDTH: value for the addressed leaf, base_q + leaf_sel.
- leaf_valid, out, 1: transfer request.
- leaf_ack, in, 1: the addressed leaf accepts leaf_data this cycle.
- leaf_echo, in, WIDTH: the leaf's current stored value. Valid when leaf_ack is high.
- busy, out, 1: high in SEND and HOLD.
- done, out, 1: high in DONE.
- err, out, 1: sticky error flag. Cleared only by reset or by an accepted start.
- cyc, out, 32: post-delivery cycle counter.

## Operation
- Reset: the FSM enters IDLE. All outputs are 0 (leaf_sel=0, leaf_data=0, cyc=0, err=0). idx, base_q and the timeout counter tmo are 0.
- IDLE:
  - On start: latch base_q=base, set idx=NLEAF-1, tmo=0, err=0, then go to SEND.
- SEND:
  - Drive leaf_valid=1, leaf_sel=idx, leaf_data=base_q+idx. The addition wraps modulo 2^WIDTH.
  - If leaf_ack=1, the transfer completes this cycle:
    - If leaf_echo != leaf_data, set err. The echo is combinational from the leaf.
    - If idx==0, go to HOLD with cyc=0. Otherwise decrement idx and reset tmo=0.
  - If leaf_ack=0, increment tmo. When tmo reaches TIMEOUT-1 with no ack, set err and advance exactly as on ack. The stalled leaf is skipped.
  - Leaves are served in descending order: NLEAF-1 first, 0 last.
- HOLD:
  - leaf_valid=0.
  - cyc increments by 1 each cycle.
  - When cyc==LAST, go to DONE. cyc holds at LAST.
- DONE:
  - done=1, and all outputs are held.
  - A start here behaves exactly as start in IDLE and restarts the run.
- start in SEND or HOLD is ignored.
- leaf_ack while leaf_valid=0 is ignored and has no effect on err.
- reset_l low in any state: immediate asynchronous return to IDLE with reset values, including mid-transfer. A half-complete run is abandoned.

## Timing
- start sampled high at edge T: leaf_valid is high from T+1.
- With immediate ack: one leaf per cycle, so SEND lasts NLEAF cycles.
  - The first HOLD cycle shows cyc=0.
  - done rises LAST cycles after HOLD entry.
  - Total with NLEAF=4 and LAST=13: done high at T+1+4+13 = T+18.
- A stalled leaf occupies exactly TIMEOUT cycles in SEND.
- err is registered and visible the cycle after the failing transfer.
- leaf_data and leaf_sel are stable while leaf_valid is high and unacked.

## Test plan
- Immediate ack, base=0, correct echo: leaf_sel sequence 3,2,1,0 with leaf_data 3,2,1,0. err=0. done at start+18. cyc=13 in DONE.
- base=32'hFFFF_FFFE: leaf_data sequence 1,0,FFFF_FFFF,FFFF_FFFE (wraps). No error.
- Leaf 2 echoes a wrong value (e.g. 7): err=1 from the cycle after its ack. The run still completes, and done asserts with err=1.
- Leaf 1 never acks, TIMEOUT=8: leaf_sel=1 held for 8 cycles, err=1, then leaf 0 is served and done follows. ack delayed 3 cycles on leaf 3 instead: no err, done delayed 3 cycles.
- start pulsed during SEND and HOLD is ignored. start in DONE with base=10 restarts the run: err cleared, leaf_data 13,12,11,10.
- reset_l dropped mid-SEND (idx=2): outputs return to 0 immediately. After release, the FSM is IDLE and the next start runs a full sequence from leaf 3.
